// File: rtl/apb_cmd_sequencer.sv
// apb_cmd_sequencer: APB master that replays a queued list of write and
// read-and-check commands into an APB slave, counting read mismatches.
// Optional feature macro: APB_SEQ_TIMEOUT_EN (aborts a replay when PREADY
// stays low for TIMEOUT ACCESS cycles; without it ACCESS waits forever).
module apb_cmd_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int ERR_W   = 8,
    parameter int TIMEOUT = 256
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [DATA_W-1:0] cmd_mask,
    input  logic              start,
    input  logic              clr_err,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err_count,
    output logic              timeout_err,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Reject parameter sets the pointer arithmetic cannot handle.
    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
            $error("apb_cmd_sequencer: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Command storage; read combinationally so SETUP can present the head at once.
    logic [ADDR_W-1:0] addr_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem  [DEPTH];
    logic [DATA_W-1:0] mask_mem  [DEPTH];
    logic              write_mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;

    logic              done_reg;
    logic              rd_valid_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic [ERR_W-1:0]  err_count_reg;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              more;
    logic              abort;
    logic              done_set;
    logic              mismatch;
    logic              rd_complete;
    logic              timeout_hit;

    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] head_mask;
    logic              head_write;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;

    assign full       = (count_reg == CNT_W'(DEPTH));
    assign empty      = (count_reg == '0);
    assign cmd_ready  = !full;
    assign push       = cmd_valid && !full;

    assign head_addr  = addr_mem[rd_ptr_reg];
    assign head_data  = data_mem[rd_ptr_reg];
    assign head_mask  = mask_mem[rd_ptr_reg];
    assign head_write = write_mem[rd_ptr_reg];

    // Another command remains after popping the head, counting a same-cycle push.
    assign more        = (count_reg > CNT_W'(1)) || push;
    assign mismatch    = |((PRDATA ^ head_data) & head_mask);
    assign rd_complete = pop && !head_write;

    // Write accepted commands into the slot at the write pointer.
    always_ff @(posedge PCLK) begin
        if (push) begin
            addr_mem[wr_ptr_reg]  <= cmd_addr;
            data_mem[wr_ptr_reg]  <= cmd_data;
            mask_mem[wr_ptr_reg]  <= cmd_mask;
            write_mem[wr_ptr_reg] <= cmd_write;
        end
    end

    // FIFO pointers and occupancy; a timeout abort discards everything queued.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (abort) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and APB drive; bus outputs follow the state so reset drops them at once.
    always_comb begin
        state_next = state_reg;
        psel       = 1'b0;
        penable    = 1'b0;
        pwrite     = 1'b0;
        paddr      = '0;
        pwdata     = '0;
        pop        = 1'b0;
        abort      = 1'b0;
        done_set   = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    if (empty) begin
                        done_set = 1'b1;
                    end else begin
                        state_next = SETUP;
                    end
                end
            end
            SETUP: begin
                psel       = 1'b1;
                pwrite     = head_write;
                paddr      = head_addr;
                pwdata     = head_write ? head_data : '0;
                state_next = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                pwrite  = head_write;
                paddr   = head_addr;
                pwdata  = head_write ? head_data : '0;
                if (PREADY) begin
                    pop = 1'b1;
                    if (more) begin
                        state_next = SETUP;
                    end else begin
                        state_next = IDLE;
                        done_set   = 1'b1;
                    end
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                    done_set   = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered status: completion pulses, read capture and saturating mismatch count.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            done_reg      <= 1'b0;
            rd_valid_reg  <= 1'b0;
            rd_data_reg   <= '0;
            err_count_reg <= '0;
        end else begin
            done_reg     <= done_set;
            rd_valid_reg <= rd_complete;
            if (rd_complete) begin
                rd_data_reg <= PRDATA;
            end
            if (clr_err) begin
                err_count_reg <= '0;
            end else if (rd_complete && mismatch && (err_count_reg != '1)) begin
                err_count_reg <= err_count_reg + ERR_W'(1);
            end
        end
    end

`ifdef APB_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] wait_cnt_reg;
    logic            timeout_err_reg;

    // Count stalled ACCESS cycles; restart on completion or any other state.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt_reg <= '0;
        end else if ((state_reg == ACCESS) && !PREADY) begin
            wait_cnt_reg <= wait_cnt_reg + TO_W'(1);
        end else begin
            wait_cnt_reg <= '0;
        end
    end

    assign timeout_hit = (state_reg == ACCESS) && !PREADY &&
                         (wait_cnt_reg == TO_W'(TIMEOUT - 1));

    // Sticky timeout flag; clearing takes priority over a same-cycle abort.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            timeout_err_reg <= 1'b0;
        end else if (clr_err) begin
            timeout_err_reg <= 1'b0;
        end else if (abort) begin
            timeout_err_reg <= 1'b1;
        end
    end

    assign timeout_err = timeout_err_reg;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign rd_valid  = rd_valid_reg;
    assign rd_data   = rd_data_reg;
    assign err_count = err_count_reg;
    assign PSELx     = psel;
    assign PENABLE   = penable;
    assign PWRITE    = pwrite;
    assign PADDR     = paddr;
    assign PWDATA    = pwdata;

endmodule
